// File: rtl/aes_ctr_stream.sv
// rtl/aes_ctr_stream.sv - streaming AES-128 CTR encryptor/decryptor with output FIFO
//
// aes_ctr_stream: accepts 128-bit blocks on a valid/ready input, encrypts the
// running counter block with AES-128 and emits in_data XOR keystream through a
// FIFO_DEPTH-entry output FIFO. Encryption and decryption are the same operation.
//   clk, rstn          clock, synchronous active-low reset (also resets the engine)
//   cfg_load/key/iv    one-cycle pulse latching key and initial counter block
//   in_valid/ready/data/last   input block stream
//   out_valid/ready/data/last  output block stream (FIFO head)
//   busy               block in flight or FIFO non-empty
//   blk_count          blocks pushed since the last accepted cfg_load
//   ctr_wrap_err       sticky counter-wrap flag (only with AES_CTR_WRAP_ERR_EN)
// Optional macro: AES_CTR_WRAP_ERR_EN - stop accepting blocks once the counter
// field wraps, until the next cfg_load.
//
// AES_top: iterative AES-128 engine, one round per clock.
//   start pulse loads plain_text/cipher_key; done pulses with cipher_text valid.

module AES_top (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [127:0] plain_text,
  input  logic [127:0] cipher_key,
  output logic         done,
  output logic [127:0] cipher_text
);
  logic [127:0] rk, rk_n, sb, sr, mc, rnd_out;
  logic [31:0]  tw, w0, w1, w2, w3;
  logic [7:0]   rcon, a0, a1, a2, a3;
  logic [3:0]   rnd;
  logic         run;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (product of x^2..x^128), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    sb = '0; sr = '0; mc = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    // Next round key from the current one; rcon advances alongside.
    tw = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rcon, 24'h0};
    w0 = rk[127:96] ^ tw;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    rk_n = {w0, w1, w2, w3};
    for (int i = 0; i < 16; i++)
      sb[127-8*i -: 8] = sbox(cipher_text[127-8*i -: 8]);
    // Byte index is row + 4*column; row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    // The final round skips MixColumns.
    rnd_out = ((rnd == 4'd10) ? sr : mc) ^ rk_n;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cipher_text <= '0;
      rk          <= '0;
      rcon        <= '0;
      rnd         <= '0;
      run         <= 1'b0;
      done        <= 1'b0;
    end else if (start) begin
      cipher_text <= plain_text ^ cipher_key;
      rk          <= cipher_key;
      rcon        <= 8'h01;
      rnd         <= 4'd1;
      run         <= 1'b1;
      done        <= 1'b0;
    end else if (run) begin
      cipher_text <= rnd_out;
      rk          <= rk_n;
      rcon        <= xt(rcon);
      rnd         <= rnd + 4'd1;
      run         <= (rnd != 4'd10);
      done        <= (rnd == 4'd10);
    end else begin
      done        <= 1'b0;
    end
  end
endmodule

module aes_ctr_stream #(
  parameter int CTR_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic [31:0]  blk_count,
  output logic         ctr_wrap_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];
  // Only the low CTR_W bits of the counter block ever change.
  localparam logic [127:0] LOW_MASK = {128{1'b1}} >> (128 - CTR_W);

  typedef enum logic [2:0] {UNCFG, IDLE, START, WAIT, PUSH} state_t;
  state_t state, state_n;

  logic [127:0] key_q, ctr_q, data_q, ks_q, eng_ct;
  logic         last_q, eng_done;
  logic [128:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]  count;
  logic         hs, cfg_ok, push, pop, empty, ctr_full, can_accept;

  AES_top u_aes (
    .clk         (clk),
    .rstn        (rstn),
    .start       (state == START),
    .plain_text  (ctr_q),
    .cipher_key  (key_q),
    .done        (eng_done),
    .cipher_text (eng_ct)
  );

  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr][127:0];
  assign out_last  = !empty && mem[rd_ptr][128];
  assign push      = (state == PUSH);
  assign pop       = out_valid && out_ready;
  assign hs        = in_valid && in_ready;
  assign busy      = (state == START) || (state == WAIT) || (state == PUSH) || !empty;
  assign ctr_full  = ((ctr_q & LOW_MASK) == LOW_MASK);
  assign can_accept = (state == IDLE) && (count < DEPTH_C);
  // A cfg_load that coincides with an accepted block would change key/ctr under it.
  assign cfg_ok    = cfg_load && ((state == UNCFG) || ((state == IDLE) && !hs));

`ifdef AES_CTR_WRAP_ERR_EN
  logic wrap_err;
  assign in_ready     = can_accept && !wrap_err;
  assign ctr_wrap_err = wrap_err;

  always_ff @(posedge clk) begin
    if (!rstn || cfg_ok) wrap_err <= 1'b0;
    else if (push && ctr_full) wrap_err <= 1'b1;
  end
`else
  assign in_ready     = can_accept;
  assign ctr_wrap_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      UNCFG: if (cfg_load) state_n = IDLE;
      IDLE:  if (hs) state_n = START;
      START: state_n = WAIT;
      WAIT:  if (eng_done) state_n = PUSH;
      PUSH:  state_n = IDLE;
      default: state_n = UNCFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= UNCFG;
      key_q     <= '0;
      ctr_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      ks_q      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      blk_count <= '0;
    end else begin
      state <= state_n;
      if (cfg_ok) begin
        key_q     <= cfg_key;
        ctr_q     <= cfg_iv;
        blk_count <= '0;
      end
      if (hs) begin
        data_q <= in_data;
        last_q <= in_last;
      end
      if ((state == WAIT) && eng_done) ks_q <= eng_ct;
      if (push) begin
        ctr_q     <= (ctr_q & ~LOW_MASK) | ((ctr_q + 128'd1) & LOW_MASK);
        blk_count <= blk_count + 32'd1;
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push) mem[wr_ptr] <= {last_q, data_q ^ ks_q};
  end
endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb/tb_aes_ctr_stream.sv - scoreboard testbench for aes_ctr_stream
module tb_aes_ctr_stream;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cfg_load = 1'b0;
  logic [127:0] cfg_key = '0, cfg_iv = '0;
  logic         in_valid = 1'b0, in_last = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, out_last, busy, ctr_wrap_err;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [31:0]  blk_count;

  int checks = 0;
  int failures = 0;

  logic [128:0] exp_q [$];
  logic [127:0] ctr_exp_q [$];
  logic [127:0] mkey, mctr;
  logic [7:0]   sbt [256];
  logic [128:0] mon_e;
  logic [127:0] mon_c;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_IV  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_ctr_stream #(.CTR_W(32), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rstn(rstn), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .blk_count(blk_count), .ctr_wrap_err(ctr_wrap_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[x] = b;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [127:0] k, input logic [127:0] iv);
    cfg_key = k; cfg_iv = iv; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    mkey = k; mctr = iv;
  endtask

  task automatic send(input logic [127:0] d, input logic last, input bit track);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 129'(ok), 129'd1);
    if (ok) begin
      step();
      ctr_exp_q.push_back(mctr);
      if (track) exp_q.push_back({last, d ^ aes_ref(mkey, mctr)});
      mctr = {mctr[127:32], mctr[31:0] + 32'd1};
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    chk(tag, 129'(n < 400), 129'd1);
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 129'(in_ready), 129'd0);
    chk({tag, "_out_valid"}, 129'(out_valid), 129'd0);
    chk({tag, "_out_last"}, 129'(out_last), 129'd0);
    chk({tag, "_busy"}, 129'(busy), 129'd0);
    chk({tag, "_wrap_err"}, 129'(ctr_wrap_err), 129'd0);
    chk({tag, "_out_data"}, 129'(out_data), 129'd0);
    chk({tag, "_blk_count"}, 129'(blk_count), 129'd0);
  endtask

  // Output scoreboard and engine-input checker.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", 129'(exp_q.size()), 129'd1);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 129'(out_data), 129'(mon_e[127:0]));
        chk("out_last", 129'(out_last), 129'(mon_e[128]));
      end
    end
    if (rstn && u_dut.u_aes.start) begin
      if (ctr_exp_q.size() == 0) chk("unexpected_start", 129'(ctr_exp_q.size()), 129'd1);
      else begin
        mon_c = ctr_exp_q.pop_front();
        chk("engine_ctr", 129'(u_dut.u_aes.plain_text), 129'(mon_c));
      end
    end
  end

  initial begin
    logic [127:0] kA, ivA, d5;
    int hi;
    build_sbox();
    mkey = '0; mctr = '0;

    // Reset state and UNCFG refusal.
    repeat (2) step();
    @(negedge clk);
    chk_reset_outputs("reset");
    step();
    rstn = 1'b1;
    in_valid = 1'b1;
    hi = 0;
    repeat (3) begin @(negedge clk); if (in_ready) hi++; end
    chk("uncfg_in_ready", 129'(hi), 129'd0);
    step();
    in_valid = 1'b0;

    // FIPS-197 known-answer block.
    cfg(FIPS_KEY, FIPS_IV);
    send('0, 1'b1, 1'b0);
    exp_q.push_back({1'b1, FIPS_CT});
    wait_idle("fips_drain");
    chk("fips_blk_count", 129'(blk_count), 129'd1);

    // Three-block message: counter crosses a byte boundary.
    cfg(FIPS_KEY, FIPS_IV);
    send(rnd128(), 1'b0, 1'b1);
    send(rnd128(), 1'b0, 1'b1);
    send(rnd128(), 1'b1, 1'b1);
    wait_idle("multi_drain");
    chk("multi_blk_count", 129'(blk_count), 129'd3);

    // Backpressure: FIFO fills at 4, fifth block refused until the sink drains.
    cfg(rnd128(), rnd128());
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(rnd128(), 1'(i == 3), 1'b1);
    d5 = rnd128();
    in_valid = 1'b1; in_data = d5;
    hi = 0;
    repeat (40) begin @(negedge clk); if (in_ready) hi++; end
    chk("bp_in_ready_low", 129'(hi), 129'd0);
    chk("bp_blk_count", 129'(blk_count), 129'd4);
    chk("bp_busy", 129'(busy), 129'd1);
    chk("bp_head_hold", 129'(out_data), 129'(exp_q[0][127:0]));
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(d5, 1'b0, 1'b1);
    send(rnd128(), 1'b1, 1'b1);
    wait_idle("bp_drain");
    chk("bp_final_count", 129'(blk_count), 129'd6);

    // Counter field wrap (low 32 bits).
    kA = rnd128();
    cfg(kA, {96'h0123456789abcdef01234567, 32'hffff_fffe});
    send(rnd128(), 1'b0, 1'b1);
    send(rnd128(), 1'b0, 1'b1);
`ifdef AES_CTR_WRAP_ERR_EN
    wait_idle("wrap_drain");
    chk("wrap_err_set", 129'(ctr_wrap_err), 129'd1);
    in_valid = 1'b1;
    hi = 0;
    repeat (5) begin @(negedge clk); if (in_ready) hi++; end
    chk("wrap_in_ready", 129'(hi), 129'd0);
    step();
    in_valid = 1'b0;
    chk("wrap_blk_count", 129'(blk_count), 129'd2);
    cfg(kA, {96'h0123456789abcdef01234567, 32'h0000_0000});
    chk("wrap_err_cleared", 129'(ctr_wrap_err), 129'd0);
    send(rnd128(), 1'b1, 1'b1);
    wait_idle("wrap_resume");
`else
    send(rnd128(), 1'b1, 1'b1);
    wait_idle("wrap_drain");
    chk("wrap_err_tied", 129'(ctr_wrap_err), 129'd0);
    chk("wrap_blk_count", 129'(blk_count), 129'd3);
`endif

    // cfg_load while the engine is busy must be ignored.
    kA = rnd128(); ivA = rnd128();
    cfg(kA, ivA);
    send(rnd128(), 1'b0, 1'b1);
    repeat (4) step();
    cfg_key = ~kA; cfg_iv = ~ivA; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    send(rnd128(), 1'b1, 1'b1);
    wait_idle("cfgwait_drain");
    chk("cfgwait_blk_count", 129'(blk_count), 129'd2);

    // Reset while the engine is mid-block, then a clean FIPS block.
    send(rnd128(), 1'b1, 1'b0);
    repeat (4) step();
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midrst");
    step();
    rstn = 1'b1;
    cfg(FIPS_KEY, FIPS_IV);
    send('0, 1'b1, 1'b0);
    exp_q.push_back({1'b1, FIPS_CT});
    wait_idle("midrst_drain");
    chk("midrst_blk_count", 129'(blk_count), 129'd1);

    repeat (5) step();
    chk("exp_q_empty", 129'(exp_q.size()), 129'd0);
    chk("ctr_q_empty", 129'(ctr_exp_q.size()), 129'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
